// File: rtl/tlp_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlp_arb_pkg : shared types and the rotating one-hot pick function. Rev 1.0
// ----------------------------------------------------------------------------
package tlp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_CH     = 8;

  // First requester at or after ptr, wrapping within the n active channels.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [MAX_CH-1:0] gnt;
    logic              found;
    int                idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_arb_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlp_arb_rr_pick : combinational one-hot picker, fixed or rotated priority. Rev 1.0
// ----------------------------------------------------------------------------
module tlp_arb_rr_pick
  import tlp_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = MODE_RR,
  parameter int PTR_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [PTR_W-1:0]  idx_o
);

  logic [MAX_CH-1:0] w_req_ext;
  logic [MAX_CH-1:0] w_pick;
  logic [2:0]        w_ptr;

  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NUM_CH-1:0] = req_i;
    // Fixed priority is a rotation that always starts at channel 0.
    w_ptr                 = 3'd0;
    if (RR_MODE == MODE_RR) w_ptr = 3'(ptr_i);
    w_pick = rr_pick(w_req_ext, w_ptr, NUM_CH);
    gnt_o  = w_pick[NUM_CH-1:0];
    idx_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pick[i]) idx_o = PTR_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlp_tx_arb_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlp_tx_arb_rr : packet-locked N-channel TLP TX arbiter with watchdog. Rev 1.0
// ----------------------------------------------------------------------------
module tlp_tx_arb_rr
  import tlp_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RR_MODE    = MODE_RR,
  parameter int WDOG_CYC   = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                         clk_125,
  input  logic                         rstn,
  input  logic                         tx_val,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]            ch_sop,
  input  logic [NUM_CH-1:0]            ch_eop,
  input  logic [NUM_CH-1:0]            ch_dwen,
  output logic [NUM_CH-1:0]            ch_rdy,
  output logic                         tx_req,
  output logic [DATA_WIDTH-1:0]        tx_dout,
  output logic                         tx_sop,
  output logic                         tx_eop,
  output logic                         tx_dwen,
  input  logic                         tx_rdy,
  output logic [NUM_CH-1:0]            grant_vec,
  output logic                         wdog_evt,
  output logic [NUM_CH*CNT_W-1:0]      tlp_cnt,
  input  logic                         cnt_clr
);

  localparam int c_ptr_w  = $clog2(NUM_CH);
  localparam int c_wd_w   = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam int c_wd_lim = (WDOG_CYC > 0) ? WDOG_CYC - 1 : 0;

  arb_state_e          state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [c_ptr_w-1:0]  gidx_q, gidx_d;
  logic [c_ptr_w-1:0]  ptr_q, ptr_d;
  logic [c_wd_w-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];

  logic [NUM_CH-1:0]     w_pick;
  logic [c_ptr_w-1:0]    w_pick_idx;
  logic                  w_req_g, w_sop_g, w_eop_g, w_dwen_g;
  logic [DATA_WIDTH-1:0] w_din_g;
  logic                  w_held, w_done, w_force_eop, w_wdog_hit;

  tlp_arb_rr_pick #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE),
    .PTR_W   (c_ptr_w)
  ) u_pick (
    .req_i (ch_req),
    .ptr_i (ptr_q),
    .gnt_o (w_pick),
    .idx_o (w_pick_idx)
  );

  assign w_req_g    = ch_req[gidx_q];
  assign w_sop_g    = ch_sop[gidx_q];
  assign w_eop_g    = ch_eop[gidx_q];
  assign w_dwen_g   = ch_dwen[gidx_q];
  assign w_din_g    = ch_din[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign w_held     = (state_q != IDLE);
  assign w_wdog_hit = (WDOG_CYC != 0) && (wdog_q == c_wd_w'(c_wd_lim));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    wdog_d      = wdog_q;
    w_done      = 1'b0;
    w_force_eop = 1'b0;
    wdog_evt    = 1'b0;
    // Saturating so a sop accepted on the limit cycle still releases next cycle.
    if (w_held && (WDOG_CYC != 0) && !w_wdog_hit) wdog_d = wdog_q + 1'b1;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (|ch_req) begin
          grant_d = w_pick;
          gidx_d  = w_pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (tx_val && w_sop_g && w_eop_g) begin
          w_done = 1'b1;
        end else if (tx_val && w_sop_g) begin
          state_d = XFER;
        end else if (!w_req_g) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (w_wdog_hit) begin
          state_d  = IDLE;
          grant_d  = '0;
          wdog_evt = 1'b1;
        end
      end
      XFER: begin
        if (tx_val && w_eop_g) begin
          w_done = 1'b1;
        end else if (w_wdog_hit) begin
          state_d     = IDLE;
          grant_d     = '0;
          wdog_evt    = 1'b1;
          w_force_eop = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (w_done) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = (gidx_q == c_ptr_w'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
      always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn)                                   cnt_q[k] <= '0;
        else if (cnt_clr)                            cnt_q[k] <= '0;
        else if (w_done && (gidx_q == c_ptr_w'(k)))  cnt_q[k] <= cnt_q[k] + 1'b1;
      end
      assign tlp_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  endgenerate

  assign grant_vec = grant_q;
  assign ch_rdy    = grant_q & {NUM_CH{tx_rdy}};
  assign tx_req    = w_held & w_req_g;
  assign tx_dout   = w_held ? w_din_g : '0;
  assign tx_sop    = w_held & w_sop_g;
  assign tx_eop    = w_held & (w_eop_g | w_force_eop);
  assign tx_dwen   = (DATA_WIDTH == 64) & w_held & w_dwen_g;

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_arb_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tlp_tx_arb_rr : directed scoreboard bench, RR/64-bit/wdog and fixed-priority DUTs. Rev 1.0
// ----------------------------------------------------------------------------
module tb_tlp_tx_arb_rr;

  logic         clk_125 = 1'b0;
  logic         a_rstn, b_rstn, tx_val, tx_rdy, cnt_clr;
  logic [3:0]   ch_req, ch_sop, ch_eop, ch_dwen;
  logic [255:0] ch_din;

  logic [3:0]  a_ch_rdy, a_grant, b_ch_rdy, b_grant;
  logic        a_tx_req, a_tx_sop, a_tx_eop, a_tx_dwen, a_wdog;
  logic        b_tx_req, b_tx_sop, b_tx_eop, b_tx_dwen, b_wdog;
  logic [63:0] a_tx_dout, a_cnt, b_tx_dout, b_cnt;

  int          total, bad, ch;
  logic        use_b, mon_on, in_pkt;
  logic [3:0]  prev_g, eg, m_gnt;
  logic [66:0] exp_b;
  logic [63:0] m_dout;
  logic        m_sop, m_eop, m_dwen;
  logic [66:0] exp_beats [$];
  logic [3:0]  exp_gnt [$];

  always #4 clk_125 = ~clk_125;

  tlp_tx_arb_rr #(.NUM_CH(4), .DATA_WIDTH(64), .RR_MODE(1), .WDOG_CYC(16), .CNT_W(16)) u_dut_a (
    .clk_125(clk_125), .rstn(a_rstn), .tx_val(tx_val), .ch_req(ch_req), .ch_din(ch_din),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_dwen(ch_dwen), .ch_rdy(a_ch_rdy), .tx_req(a_tx_req),
    .tx_dout(a_tx_dout), .tx_sop(a_tx_sop), .tx_eop(a_tx_eop), .tx_dwen(a_tx_dwen), .tx_rdy(tx_rdy),
    .grant_vec(a_grant), .wdog_evt(a_wdog), .tlp_cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  tlp_tx_arb_rr #(.NUM_CH(4), .DATA_WIDTH(64), .RR_MODE(0), .WDOG_CYC(0), .CNT_W(16)) u_dut_b (
    .clk_125(clk_125), .rstn(b_rstn), .tx_val(tx_val), .ch_req(ch_req), .ch_din(ch_din),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_dwen(ch_dwen), .ch_rdy(b_ch_rdy), .tx_req(b_tx_req),
    .tx_dout(b_tx_dout), .tx_sop(b_tx_sop), .tx_eop(b_tx_eop), .tx_dwen(b_tx_dwen), .tx_rdy(tx_rdy),
    .grant_vec(b_grant), .wdog_evt(b_wdog), .tlp_cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  always_comb begin
    m_gnt  = use_b ? b_grant   : a_grant;
    m_dout = use_b ? b_tx_dout : a_tx_dout;
    m_sop  = use_b ? b_tx_sop  : a_tx_sop;
    m_eop  = use_b ? b_tx_eop  : a_tx_eop;
    m_dwen = use_b ? b_tx_dwen : a_tx_dwen;
  end

  // Scoreboard: grant starts and accepted beats are popped against expectations.
  always @(negedge clk_125) begin
    if (m_gnt != 4'd0 && prev_g == 4'd0) begin
      total++;
      if (exp_gnt.size() == 0) begin
        bad++;
        $error("FAIL grant_unexp observed=%0h expected=none", m_gnt);
      end else begin
        eg = exp_gnt.pop_front();
        assert (m_gnt === eg) else begin
          bad++;
          $error("FAIL grant_order observed=%0h expected=%0h", m_gnt, eg);
        end
      end
    end
    prev_g = m_gnt;
    if (!mon_on || m_gnt == 4'd0) begin
      in_pkt = 1'b0;
    end else if (tx_val && (m_sop || in_pkt)) begin
      total++;
      if (exp_beats.size() == 0) begin
        bad++;
        $error("FAIL beat_unexp observed=%0h expected=none", {m_dout, m_sop, m_eop, m_dwen});
      end else begin
        exp_b = exp_beats.pop_front();
        assert ({m_dout, m_sop, m_eop, m_dwen} === exp_b) else begin
          bad++;
          $error("FAIL beat observed=%0h expected=%0h", {m_dout, m_sop, m_eop, m_dwen}, exp_b);
        end
      end
      in_pkt = !m_eop;
    end
  end

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, output int gch);
    logic [3:0] g;
    gch = -1;
    for (int i = 0; i < 40 && gch < 0; i++) begin
      tick();
      g = use_b ? b_grant : a_grant;
      for (int k = 0; k < 4; k++) if (g[k]) gch = k;
    end
    if (gch < 0) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=none expected=grant", tag);
      gch = 0;
    end
  endtask

  task automatic drive_tlp(input int dch, input int n, input bit dw);
    for (int b = 0; b < n; b++) begin
      ch_din[dch*64 +: 64] = {$urandom, $urandom};
      ch_sop[dch]  = (b == 0);
      ch_eop[dch]  = (b == n - 1);
      ch_dwen[dch] = dw && (b == n - 1);
      exp_beats.push_back({ch_din[dch*64 +: 64], ch_sop[dch], ch_eop[dch], ch_dwen[dch]});
      tick();
    end
    ch_sop[dch]  = 1'b0;
    ch_eop[dch]  = 1'b0;
    ch_dwen[dch] = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; use_b = 1'b0; mon_on = 1'b1; in_pkt = 1'b0; prev_g = 4'd0;
    a_rstn = 1'b0; b_rstn = 1'b0; tx_val = 1'b1; tx_rdy = 1'b1; cnt_clr = 1'b0;
    ch_req = 4'd0; ch_sop = 4'd0; ch_eop = 4'd0; ch_dwen = 4'd0; ch_din = '0;
    repeat (3) tick();
    chk("rst_grant", a_grant, 0);
    chk("rst_txreq", a_tx_req, 0);
    chk("rst_chrdy", a_ch_rdy, 0);
    chk("rst_wdog", a_wdog, 0);
    chk("rst_cnt", a_cnt, 0);
    a_rstn = 1'b1;

    // Round-robin with all four channels requesting, 3-beat TLPs.
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0100);
    exp_gnt.push_back(4'b1000); exp_gnt.push_back(4'b0001);
    ch_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr", ch);
      drive_tlp(ch, 3, 1'b0);
      if (k == 3) chk("rr_cnt4", a_cnt, {16'd1, 16'd1, 16'd1, 16'd1});
    end
    ch_req = 4'd0;
    tick();
    chk("rr_cnt5", a_cnt, {16'd1, 16'd1, 16'd1, 16'd2});

    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr", a_cnt, 0);

    // Clear coincides with the completing beat of a ch2 TLP.
    exp_gnt.push_back(4'b0100);
    ch_req = 4'b0100;
    wait_gnt("clr_inc", ch);
    cnt_clr = 1'b1;
    drive_tlp(ch, 1, 1'b1);
    cnt_clr = 1'b0; ch_req = 4'd0;
    chk("clr_prio", a_cnt, 0);
    chk("clr_gnt", a_grant, 0);

    // 64-bit single-beat TLP with dwen, tx_val low on the first presented cycle.
    exp_gnt.push_back(4'b0010);
    ch_req = 4'b0010;
    wait_gnt("sb", ch);
    ch_din[ch*64 +: 64] = 64'hDEAD_BEEF_0123_4567;
    ch_sop[ch] = 1'b1; ch_eop[ch] = 1'b1; ch_dwen[ch] = 1'b1; tx_val = 1'b0;
    exp_beats.push_back({64'hDEAD_BEEF_0123_4567, 3'b111});
    tick();
    chk("sb_hold", a_grant, 4'b0010);
    tx_val = 1'b1;
    tick();
    ch_sop = 4'd0; ch_eop = 4'd0; ch_dwen = 4'd0; ch_req = 4'd0;
    chk("sb_cnt", a_cnt[31:16], 1);
    chk("sb_gnt", a_grant, 0);
    chk("idle_dout", a_tx_dout, 0);

    // Watchdog: ch0 sends sop but never eop.
    mon_on = 1'b0;
    exp_gnt.push_back(4'b0001);
    ch_req = 4'b0001;
    wait_gnt("wd", ch);
    ch_din[63:0] = 64'h0000_1111_2222_3333;
    ch_sop[0] = 1'b1;
    tick();
    ch_sop[0] = 1'b0;
    repeat (13) tick();
    chk("wd_pre_evt", a_wdog, 0);
    chk("wd_pre_eop", a_tx_eop, 0);
    tick();
    chk("wd_evt", a_wdog, 1);
    chk("wd_eop", a_tx_eop, 1);
    ch_req = 4'd0;
    tick();
    chk("wd_gnt", a_grant, 0);
    chk("wd_evt_off", a_wdog, 0);
    chk("wd_cnt", a_cnt[15:0], 0);

    // Async reset in the middle of a ch1 transfer; pointer must return to 0.
    exp_gnt.push_back(4'b0010);
    ch_req = 4'b0010;
    wait_gnt("rs", ch);
    ch_sop[1] = 1'b1;
    tick();
    ch_sop[1] = 1'b0;
    a_rstn = 1'b0;
    #1;
    chk("rs_gnt", a_grant, 0);
    chk("rs_req", a_tx_req, 0);
    chk("rs_cnt", a_cnt, 0);
    ch_req = 4'b1001;
    tick();
    a_rstn = 1'b1;
    exp_gnt.push_back(4'b0001);
    wait_gnt("rs_ptr", ch);
    ch_req = 4'd0;
    tick();

    // Fixed-priority DUT: ch1 starves ch3 until it drops.
    a_rstn = 1'b0; use_b = 1'b1;
    tick();
    b_rstn = 1'b1; mon_on = 1'b1;
    exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b1000);
    ch_req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_gnt("fx", ch);
      drive_tlp(ch, 2, 1'b0);
    end
    ch_req = 4'b1000;
    wait_gnt("fx3", ch);
    drive_tlp(ch, 1, 1'b0);
    ch_req = 4'd0;
    tick();
    chk("fx_cnt", b_cnt, {16'd1, 16'd0, 16'd3, 16'd0});

    // Core not ready for 20 cycles after grant to ch2.
    tx_rdy = 1'b0;
    exp_gnt.push_back(4'b0100);
    ch_req = 4'b0100;
    wait_gnt("st", ch);
    for (int i = 0; i < 20; i++) begin
      chk("st_hold", {b_tx_req, b_ch_rdy, b_tx_sop}, 6'b1_0000_0);
      tick();
    end
    tx_rdy = 1'b1;
    #1;
    chk("st_rdy", b_ch_rdy, 4'b0100);
    drive_tlp(ch, 2, 1'b0);
    ch_req = 4'd0;
    tick();
    chk("st_cnt", b_cnt, {16'd1, 16'd1, 16'd3, 16'd0});
    chk("idle_dout_b", b_tx_dout, 0);

    repeat (2) tick();
    chk("beats_left", exp_beats.size(), 0);
    chk("gnts_left", exp_gnt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
